// File: rtl/regfile_writeback_if.sv
// Writeback bus bundle: result producers, issue/decode queries and the register-file write port.
// The slave modport is the writeback block's view; the master modport is the surrounding core.
interface regfile_writeback_if #(
    parameter int unsigned XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            mdu_valid;
    logic            mdu_ready;
    logic [4:0]      mdu_rd;
    logic [XLEN-1:0] mdu_data;

    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      q_rs1;
    logic [4:0]      q_rs2;
    logic            hazard;
    logic [31:0]     pending;

    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    logic            fwd1_valid;
    logic            fwd2_valid;
    logic [XLEN-1:0] fwd1_data;
    logic [XLEN-1:0] fwd2_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  mdu_valid, mdu_rd, mdu_data,
        input  issue_valid, issue_rd, q_rs1, q_rs2,
        output lsu_ready, mdu_ready, hazard, pending,
        output wb_en, wb_rd, wb_data,
        output fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output mdu_valid, mdu_rd, mdu_data,
        output issue_valid, issue_rd, q_rs1, q_rs2,
        input  lsu_ready, mdu_ready, hazard, pending,
        input  wb_en, wb_rd, wb_data,
        input  fwd1_valid, fwd2_valid, fwd1_data, fwd2_data
    );
endinterface

// File: rtl/regfile_writeback.sv
// Writeback arbiter (ALU > round-robin LSU/MDU) with in-flight destination scoreboard.
// Optional decode bypass from the registered write port is built when WB_BYPASS_EN is defined.
module regfile_writeback #(
    parameter int unsigned XLEN = 32
) (
    input logic                clk_i,
    input logic                rst_ni,
    regfile_writeback_if.slave bus
);

    typedef enum logic {GrantLsu, GrantMdu} grant_e;

    grant_e          rr_last_q, rr_last_d;
    logic            wb_en_q, wb_en_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [31:0]     pending_q, pending_d;

    logic lsu_ready, mdu_ready;
    logic lsu_hs, mdu_hs;

    // Readies are forced low in reset so producers never see a handshake that gets squashed.
    always_comb begin
        lsu_ready = rst_ni && !bus.alu_valid && (!bus.mdu_valid || rr_last_q == GrantMdu);
        mdu_ready = rst_ni && !bus.alu_valid && (!bus.lsu_valid || rr_last_q == GrantLsu);
        lsu_hs    = bus.lsu_valid && lsu_ready;
        mdu_hs    = bus.mdu_valid && mdu_ready;
    end

    assign bus.lsu_ready = lsu_ready;
    assign bus.mdu_ready = mdu_ready;

    always_comb begin
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        rr_last_d = rr_last_q;
        if (bus.alu_valid) begin
            wb_en_d   = (bus.alu_rd != 5'd0);
            wb_rd_d   = bus.alu_rd;
            wb_data_d = bus.alu_data;
        end else if (lsu_hs) begin
            wb_en_d   = (bus.lsu_rd != 5'd0);
            wb_rd_d   = bus.lsu_rd;
            wb_data_d = bus.lsu_data;
            rr_last_d = GrantLsu;
        end else if (mdu_hs) begin
            wb_en_d   = (bus.mdu_rd != 5'd0);
            wb_rd_d   = bus.mdu_rd;
            wb_data_d = bus.mdu_data;
            rr_last_d = GrantMdu;
        end
    end

    // Set is applied after the clears: a same-cycle issue is a newer op and must stay pending.
    always_comb begin
        pending_d = pending_q;
        if (lsu_hs) begin
            pending_d[bus.lsu_rd] = 1'b0;
        end
        if (mdu_hs) begin
            pending_d[bus.mdu_rd] = 1'b0;
        end
        if (bus.issue_valid) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_last_q <= GrantMdu;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= '0;
            pending_q <= 32'd0;
        end else begin
            rr_last_q <= rr_last_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            pending_q <= pending_d;
        end
    end

    assign bus.hazard  = (bus.q_rs1 != 5'd0 && pending_q[bus.q_rs1])
                      || (bus.q_rs2 != 5'd0 && pending_q[bus.q_rs2])
                      || (bus.issue_valid && bus.issue_rd != 5'd0 && pending_q[bus.issue_rd]);
    assign bus.pending = pending_q;
    assign bus.wb_en   = wb_en_q;
    assign bus.wb_rd   = wb_rd_q;
    assign bus.wb_data = wb_data_q;

`ifdef WB_BYPASS_EN
    assign bus.fwd1_valid = wb_en_q && (wb_rd_q == bus.q_rs1);
    assign bus.fwd2_valid = wb_en_q && (wb_rd_q == bus.q_rs2);
    assign bus.fwd1_data  = wb_data_q;
    assign bus.fwd2_data  = wb_data_q;
`else
    assign bus.fwd1_valid = 1'b0;
    assign bus.fwd2_valid = 1'b0;
    assign bus.fwd1_data  = '0;
    assign bus.fwd2_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed scenarios followed by constrained-random traffic.
module tb_regfile_writeback;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_writeback_if #(.XLEN(XLEN)) bus ();
    regfile_writeback #(.XLEN(XLEN)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    int checks = 0;
    int passes = 0;

    // Stimulus values applied at the next step
    bit        s_rst_n;
    bit        s_alu_v, s_lsu_v, s_mdu_v, s_iss_v;
    bit [4:0]  s_alu_rd, s_lsu_rd, s_mdu_rd, s_iss_rd, s_rs1, s_rs2;
    bit [31:0] s_alu_data, s_lsu_data, s_mdu_data;

    // Reference model state
    bit        pend_m[32];
    bit        last_lsu;
    bit        exp_en;
    bit [4:0]  exp_rd;
    bit [31:0] exp_data;
    bit        lsu_hs_m, mdu_hs_m;
    wb_t       exp_q[$];
    bit        mon_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    endtask

    task automatic drive();
        rst_n           = s_rst_n;
        bus.alu_valid   = s_alu_v;
        bus.alu_rd      = s_alu_rd;
        bus.alu_data    = s_alu_data;
        bus.lsu_valid   = s_lsu_v;
        bus.lsu_rd      = s_lsu_rd;
        bus.lsu_data    = s_lsu_data;
        bus.mdu_valid   = s_mdu_v;
        bus.mdu_rd      = s_mdu_rd;
        bus.mdu_data    = s_mdu_data;
        bus.issue_valid = s_iss_v;
        bus.issue_rd    = s_iss_rd;
        bus.q_rs1       = s_rs1;
        bus.q_rs2       = s_rs2;
    endtask

    task automatic clear_stim();
        s_alu_v = 0; s_lsu_v = 0; s_mdu_v = 0; s_iss_v = 0;
        s_alu_rd = 0; s_lsu_rd = 0; s_mdu_rd = 0; s_iss_rd = 0; s_rs1 = 0; s_rs2 = 0;
        s_alu_data = 0; s_lsu_data = 0; s_mdu_data = 0;
    endtask

    // One cycle: check registered state, apply stimulus, check combinational outputs, advance model.
    task automatic step();
        bit          lr, mr, haz;
        logic [31:0] pend_vec;
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) pend_vec[i] = pend_m[i];
        chk("wb_en", {31'b0, bus.wb_en}, {31'b0, exp_en});
        chk("wb_rd", {27'b0, bus.wb_rd}, {27'b0, exp_rd});
        chk("wb_data", bus.wb_data, exp_data);
        chk("pending", bus.pending, pend_vec);
        drive();
        #1;
        lr  = s_rst_n && !s_alu_v && (!s_mdu_v || !last_lsu);
        mr  = s_rst_n && !s_alu_v && (!s_lsu_v || last_lsu);
        haz = (s_rs1 != 0 && pend_m[s_rs1]) || (s_rs2 != 0 && pend_m[s_rs2])
           || (s_iss_v && s_iss_rd != 0 && pend_m[s_iss_rd]);
        chk("lsu_ready", {31'b0, bus.lsu_ready}, {31'b0, lr});
        chk("mdu_ready", {31'b0, bus.mdu_ready}, {31'b0, mr});
        chk("hazard", {31'b0, bus.hazard}, {31'b0, haz});
        lsu_hs_m = s_lsu_v && lr;
        mdu_hs_m = s_mdu_v && mr;
        if (!s_rst_n) begin
            for (int i = 0; i < 32; i++) pend_m[i] = 0;
            last_lsu = 0; exp_en = 0; exp_rd = 0; exp_data = 0;
        end else begin
            exp_en = 0;
            if (s_alu_v) begin
                exp_rd = s_alu_rd; exp_data = s_alu_data; exp_en = (s_alu_rd != 0);
            end else if (lsu_hs_m) begin
                exp_rd = s_lsu_rd; exp_data = s_lsu_data; exp_en = (s_lsu_rd != 0);
                last_lsu = 1;
            end else if (mdu_hs_m) begin
                exp_rd = s_mdu_rd; exp_data = s_mdu_data; exp_en = (s_mdu_rd != 0);
                last_lsu = 0;
            end
            if (exp_en) exp_q.push_back('{rd: exp_rd, data: exp_data});
            if (lsu_hs_m) pend_m[s_lsu_rd] = 0;
            if (mdu_hs_m) pend_m[s_mdu_rd] = 0;
            if (s_iss_v && s_iss_rd != 0) pend_m[s_iss_rd] = 1;
        end
    endtask

    // Monitor: pops the scoreboard on every register-file write and checks the bypass outputs.
    initial begin
        wb_t cur;
        bit  cur_v;
        bit  e1, e2;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                cur_v = 0;
                cur   = '0;
                if (bus.wb_en === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("wb_spurious", {31'b0, bus.wb_en}, 32'd0);
                    end else begin
                        cur   = exp_q.pop_front();
                        cur_v = 1;
                        chk("mon_wb_rd", {27'b0, bus.wb_rd}, {27'b0, cur.rd});
                        chk("mon_wb_data", bus.wb_data, cur.data);
                    end
                end
`ifdef WB_BYPASS_EN
                e1 = cur_v && (cur.rd == bus.q_rs1);
                e2 = cur_v && (cur.rd == bus.q_rs2);
                if (e1) chk("fwd1_data", bus.fwd1_data, cur.data);
                if (e2) chk("fwd2_data", bus.fwd2_data, cur.data);
`else
                e1 = 0;
                e2 = 0;
                chk("fwd1_data", bus.fwd1_data, 32'd0);
                chk("fwd2_data", bus.fwd2_data, 32'd0);
`endif
                chk("fwd1_valid", {31'b0, bus.fwd1_valid}, {31'b0, e1});
                chk("fwd2_valid", {31'b0, bus.fwd2_valid}, {31'b0, e2});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d passes=%0d", checks, passes);
        $fatal(1);
    end

    initial begin
        bit regen_lsu, regen_mdu;
        for (int i = 0; i < 32; i++) pend_m[i] = 0;
        last_lsu = 0; exp_en = 0; exp_rd = 0; exp_data = 0;

        // Reset with every valid asserted
        clear_stim();
        s_rst_n = 0;
        s_alu_v = 1; s_lsu_v = 1; s_mdu_v = 1; s_iss_v = 1;
        s_alu_rd = 3; s_lsu_rd = 4; s_mdu_rd = 6; s_iss_rd = 8;
        drive();
        step();
        mon_on = 1;
        step();
        s_rst_n = 1;
        clear_stim();
        step();

        // x0 result is consumed without a write
        s_mdu_v = 1; s_mdu_rd = 0; s_mdu_data = 32'hFFFF_FFFF;
        step();
        chk("x0_mdu_ready", {31'b0, bus.mdu_ready}, 32'd1);
        s_mdu_v = 0;
        step();

        // Round-robin: LSU first, then alternating
        s_lsu_v = 1; s_mdu_v = 1;
        s_lsu_rd = 1; s_lsu_data = 32'h1000_0001;
        s_mdu_rd = 2; s_mdu_data = 32'h2000_0002;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_lsu_grant", {31'b0, bus.lsu_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (lsu_hs_m) begin
                s_lsu_rd = 5'(s_lsu_rd + 2); s_lsu_data = s_lsu_data + 32'h11;
            end
            if (mdu_hs_m) begin
                s_mdu_rd = 5'(s_mdu_rd + 2); s_mdu_data = s_mdu_data + 32'h22;
            end
        end
        clear_stim();
        step();

        // ALU priority over a waiting LSU result
        s_alu_v = 1; s_alu_rd = 5; s_alu_data = 32'h1234;
        s_lsu_v = 1; s_lsu_rd = 6; s_lsu_data = 32'h0000_AAAA;
        step();
        chk("alu_blocks_lsu", {31'b0, bus.lsu_ready}, 32'd0);
        s_alu_v = 0;
        step();
        s_lsu_v = 0;
        step();

        // Scoreboard set, RAW hazard, clear on completion, same-cycle set wins
        s_iss_v = 1; s_iss_rd = 7;
        step();
        s_iss_v = 0; s_rs2 = 7;
        step();
        chk("raw_hazard_rd7", {31'b0, bus.hazard}, 32'd1);
        s_lsu_v = 1; s_lsu_rd = 7; s_lsu_data = 32'h0000_0777;
        step();
        s_lsu_v = 0;
        step();
        chk("hazard_drop_rd7", {31'b0, bus.hazard}, 32'd0);
        s_iss_v = 1; s_iss_rd = 7;
        step();
        s_lsu_v = 1; s_lsu_rd = 7; s_lsu_data = 32'h0000_0778;
        step();
        s_iss_v = 0; s_lsu_v = 0;
        step();
        chk("set_wins_rd7", {31'b0, bus.pending[7]}, 32'd1);
        s_mdu_v = 1; s_mdu_rd = 7; s_mdu_data = 32'h0000_0779;
        step();
        clear_stim();
        step();

        // Bypass of the register-file write
        s_alu_v = 1; s_alu_rd = 9; s_alu_data = 32'hCAFE_F00D;
        step();
        s_alu_v = 0; s_rs1 = 9;
        step();
        clear_stim();
        step();

        // Constrained-random traffic; small register range to provoke hazards and collisions
        for (int c = 0; c < 800; c++) begin
            regen_lsu = !s_lsu_v || lsu_hs_m || !s_rst_n;
            regen_mdu = !s_mdu_v || mdu_hs_m || !s_rst_n;
            s_rst_n    = ($urandom_range(0, 99) != 0);
            s_alu_v    = ($urandom_range(0, 2) == 0);
            s_alu_rd   = 5'($urandom_range(0, 7));
            s_alu_data = $urandom;
            if (regen_lsu) begin
                s_lsu_v    = ($urandom_range(0, 1) == 0);
                s_lsu_rd   = 5'($urandom_range(0, 7));
                s_lsu_data = $urandom;
            end
            if (regen_mdu) begin
                s_mdu_v    = ($urandom_range(0, 1) == 0);
                s_mdu_rd   = 5'($urandom_range(0, 7));
                s_mdu_data = $urandom;
            end
            s_iss_v  = ($urandom_range(0, 2) == 0);
            s_iss_rd = 5'($urandom_range(0, 7));
            s_rs1    = 5'($urandom_range(0, 7));
            s_rs2    = 5'($urandom_range(0, 7));
            step();
        end

        s_rst_n = 1;
        clear_stim();
        step();
        step();
        step();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
